// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the multicycle RV32I core: FSM states, opcodes,
// datapath mux encodings and the packed control bundle.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_WAIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_ALUWB    = 4'd8,
    S_EXECI    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Purpose: decodes FSM state plus mem_ready/zero into datapath enables and mux selects.
// Latency: purely combinational, 0 cycles.
// Backpressure: FETCH enables gated by mem_rdy_i so PC/IR load once per accepted fetch.
module mc_ctrl_outdec
  import rv_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_rdy_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALURESULT;
        ctrl_o.ir_write   = mem_rdy_i;
        ctrl_o.pc_write   = mem_rdy_i;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode resolves.
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_o.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.adr_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_JAL: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_write  = zero_i;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: main Moore control FSM of the multicycle RV32I core (MCCTRL_ILLEGAL_TRAP_EN adds sticky illegal trap).
// Latency: outputs follow state in the same cycle; lw 5, sw 4, R/I/jal 4, beq 3 cycles at full mem_ready.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready (ignored when MEM_HS=0).
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter bit          MEM_HS        = 1'b1,
  parameter int unsigned RESET_PC_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       mem_rdy;
  logic       wait_done;
  ctrl_t      ctrl;

  assign mem_rdy   = MEM_HS ? mem_ready : 1'b1;
  assign wait_done = ({1'b0, wait_cnt_q} + 5'd1) >= 5'(RESET_PC_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    case (state_q)
      S_WAIT: begin
        if (wait_done) state_d = S_FETCH;
        else           wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(op))      state_d = S_MEMADR;
        else if (op == OP_R)    state_d = S_EXECR;
        else if (op == OP_I)    state_d = S_EXECI;
        else if (op == OP_JAL)  state_d = S_JAL;
        else if (op == OP_BEQ)  state_d = S_BEQ;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        else                    state_d = S_TRAP;
`else
        else                    state_d = S_FETCH;
`endif
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      // Unused encodings, and TRAP when the trap is compiled out, recover to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

`ifdef MCCTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  mc_ctrl_outdec u_outdec (
    .state_i   (state_q),
    .mem_rdy_i (mem_rdy),
    .zero_i    (zero),
    .ctrl_o    (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign state_o    = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core variant.
- Sequences the shared datapath: PC, IR, OldPC and data registers, all enabled flops, plus ALU, memory and register file.
- Emits per-state register enables and mux selects; stalls on a memory-ready handshake.
- Sits beside the datapath; consumes the opcode from the IR and the ALU zero flag.

Parameters:
- MEM_HS, 1, 1 = honour mem_ready in memory states; 0 = treat mem_ready as always 1.
- RESET_PC_WAIT, 0, cycles spent in WAIT after reset release before first FETCH (0..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- op  in  7  instr[6:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  PC flop enable
- adr_src  out  1  0 = PC, 1 = ALUOut to memory address
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR/OldPC flop enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_write  out  1  register-file write enable
- illegal  out  1  sticky illegal-opcode flag (feature-gated, else tied 0)
- state_o  out  4  current state encoding (debug)

Behaviour:
- States: WAIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, ALUWB=8, EXECI=9, JAL=10, BEQ=11, TRAP=12.
- Reset asserted: state=WAIT, wait counter=0, illegal=0.
  - All outputs are derived combinationally from the state (Moore), so all are 0 in WAIT.
- WAIT: counts RESET_PC_WAIT cycles, then goes to FETCH. With RESET_PC_WAIT=0, FETCH follows on the first edge after release.
- Transitions:
  - FETCH -> DECODE, only on a cycle with mem_ready=1; otherwise stay in FETCH.
  - DECODE, by op:
    - 0000011 (lw) and 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH (TRAP when feature enabled)
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw), using the op held in IR.
  - MEMREAD -> MEMWB on mem_ready; MEMWB -> FETCH.
  - MEMWRITE -> FETCH on mem_ready.
  - EXECR, EXECI, JAL -> ALUWB; ALUWB -> FETCH; BEQ -> FETCH.
- Outputs per state (all unlisted = 0):
  - FETCH: alu_src_b=10, result_src=10. ir_write=1 and pc_write=1 only on a cycle with mem_ready=1, so the stall is clean and PC/IR never double-update.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1 held until mem_ready.
  - EXECR: alu_src_a=10, alu_op=10.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_write=1.
  - BEQ: alu_src_a=10, alu_op=01, pc_write=zero.
- Latency in cycles with mem_ready=1: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Reset asserted mid-instruction: FSM returns to WAIT immediately and outputs drop to 0 asynchronously. An in-flight mem_write is aborted.
- Undefined state encodings (13-15) -> FETCH.

Optional Feature:
- Macro: MCCTRL_ILLEGAL_TRAP_EN.
- Defined: unknown op in DECODE -> TRAP. TRAP sets illegal=1, drives all enables 0, and stays there until reset.
- Undefined: unknown op -> FETCH (treated as NOP); TRAP state is unreachable; illegal is tied 0.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state enum / localparams
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - encodings for result_src, alu_src_a, alu_src_b and alu_op
- One natural sub-module: mc_ctrl_outdec, purely combinational (state, mem_ready, zero) -> control outputs.
- The FSM register and next-state logic stay in the top.

Test Plan:
- reset=0 then 1, RESET_PC_WAIT=2, mem_ready=1 -> state sequence 0,0,1 (2 cycles in WAIT, then FETCH); all outputs 0 while reset=0.
- op=0000011, mem_ready=1 -> states 1,2,3,4,5,1; reg_write=1 only in MEMWB with result_src=01; pc_write=1 once.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 held for 4 cycles, then FETCH; reg_write never 1.
- op=1100011, zero=1 -> pc_write=1 in BEQ; repeat with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 for those 2 cycles, then both =1 for exactly 1 cycle.
- op=1111111 -> default build: back to FETCH, illegal=0; with MCCTRL_ILLEGAL_TRAP_EN: state 12, illegal=1 held until reset=0.
